upc_mod: RTL and testbench
==========================

Name: upc_mod

Overview:
- Parameterised modulo-N up counter with enable, synchronous load, clock-enable prescaler, wrap pulse and sticky overflow flag.
- Counts 0 → MODULUS-1 → 0. It is the counting-up companion of the team's 4-bit down counter.
- Used as a general timebase and event counter. Instances can be cascaded through the wrap output.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 16, count sequence length. Legal range is 2 ≤ MODULUS ≤ 2**WIDTH.
- PRESCALE, 1, number of enabled cycles per count step. PRESCALE ≥ 1; a value of 1 means no prescaling.

Ports:
- clk  input  1  system clock; all logic is updated on the rising edge.
- rst  input  1  synchronous, active-low reset.
- en  input  1  count enable; advances the prescaler.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value captured on load.
- clr_ovf  input  1  clears the sticky overflow flag.
- count  output  WIDTH  current count, registered.
- wrap  output  1  registered single-cycle pulse on a modulo wrap.
- ovf  output  1  sticky flag, set by any wrap.

Behaviour:
- Reset:
  - rst=0 sampled at posedge sets count=0, wrap=0, ovf=0 and prescaler=0.
  - Reset mid-count takes effect on the next edge regardless of en/load.
- Priority per edge: reset > load > count step.
- Prescaler:
  - Internal counter pre runs 0..PRESCALE-1 and advances only when en=1.
  - tick = en && (pre == PRESCALE-1); on tick, pre returns to 0.
  - When PRESCALE=1, tick=en and pre is unused (constant 0).
  - en=0 freezes both pre and count.
- Count step on tick:
  - count ≠ MODULUS-1: count ← count+1, wrap ← 0.
  - count = MODULUS-1: count ← 0, wrap ← 1. wrap is high in the same cycle count first reads 0.
- wrap:
  - Deasserts on the next edge unless another wrap occurs.
  - With MODULUS=2, PRESCALE=1 and en held high, wrap is high every other cycle.
- Load:
  - load=1: count ← min(load_val, MODULUS-1); pre ← 0; wrap ← 0.
  - Load overrides a simultaneous tick. Load with en=0 is still accepted.
- Overflow:
  - ovf ← 1 on any wrap.
  - clr_ovf=1 clears ovf, except that wrap and clr_ovf in the same cycle leave ovf=1 (set wins).
  - Load does not affect ovf.
- Arithmetic: the increment is WIDTH bits wide. When MODULUS=2**WIDTH, natural rollover equals the modulo wrap; the explicit compare is still used.
- Latency: one cycle from the en edge that produces a tick to the updated count.
- Elaboration check: illegal MODULUS or PRESCALE triggers $error / $fatal.

Optional Feature:
- Macro: UPC_COMPARE_EN.
- Defined:
  - Adds input cmp_val [WIDTH] and output match [1].
  - match is registered: match ← (next count value == cmp_val), so it is high while count equals cmp_val.
  - Reset value is 0.
  - After a load equal to cmp_val, match is high on the following cycle.
- Undefined: neither port exists and no compare logic is built.

Decomposition:
- Package upc_pkg:
  - Constants UPC_DEF_WIDTH=4, UPC_DEF_MODULUS=16, UPC_DEF_PRESCALE=1.
  - Function clog2_safe (minimum result 1) for sizing the prescaler register.
- Sub-module upc_prescaler:
  - Parameter PRESCALE; ports clk, rst, en, clr, tick.
  - clr is driven by load.
  - Instantiated once inside upc_mod.

Test Plan:
1. Defaults, en=1 for 20 cycles after reset → count 0,1,…,15,0,1,2,3. wrap=1 only in the cycle count=0 after 15. ovf=1 from then on.
2. MODULUS=10, PRESCALE=3, en=1 → count steps every 3rd cycle, 0..9. wrap first asserts at cycle 30. en low for 5 cycles mid-run freezes count and pre.
3. Load: load_val=7 with en=1 → count=7 next cycle, then 8 after PRESCALE cycles. load_val=12 with MODULUS=10 → count=9. Load in the same cycle as a tick → count=load value, no wrap.
4. Overflow: wrap sets ovf. clr_ovf alone → ovf=0 next cycle. clr_ovf coincident with wrap → ovf stays 1.
5. Reset: rst=0 asserted at count=5 with en=1 and load=1 → next cycle count=0, wrap=0, ovf=0. Counting resumes from 0 one cycle after rst=1.
6. UPC_COMPARE_EN with cmp_val=3 → match high exactly while count=3, once per 16 cycles. Load of 3 → match=1 next cycle.

Source files
------------

// File: rtl/upc_pkg.sv
// Shared constants and sizing helper for the upc_mod modulo-N up counter.
package upc_pkg;

   localparam int UPC_DEF_WIDTH    = 4;
   localparam int UPC_DEF_MODULUS  = 16;
   localparam int UPC_DEF_PRESCALE = 1;

   // Register width for a 0..n-1 counter; never narrower than one bit.
   function automatic int clog2_safe(input int n);
      int r;
      r = $clog2(n);
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/upc_prescaler.sv
// Clock-enable prescaler: emits one tick every PRESCALE enabled cycles; clr restarts the phase.
module upc_prescaler
   import upc_pkg::*;
#(
   parameter int PRESCALE = UPC_DEF_PRESCALE
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int              PW       = clog2_safe(PRESCALE);
   localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

   if (PRESCALE < 1) begin : g_bad_prescale
      $error("upc_prescaler: PRESCALE must be >= 1");
   end

   logic [PW-1:0] pre;

   // With PRESCALE=1, PRE_LAST is 0, so every enabled cycle ticks and pre never leaves 0.
   assign tick = en && (pre == PRE_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         pre <= '0;
      end else if (clr || tick) begin
         pre <= '0;
      end else if (en) begin
         pre <= pre + PW'(1);
      end
   end

endmodule

// File: rtl/upc_mod.sv
// Modulo-MODULUS up counter with prescaled enable, clamped load, wrap pulse and sticky overflow.
// Optional compare output is built when UPC_COMPARE_EN is defined.
module upc_mod
   import upc_pkg::*;
#(
   parameter int WIDTH    = UPC_DEF_WIDTH,
   parameter int MODULUS  = UPC_DEF_MODULUS,
   parameter int PRESCALE = UPC_DEF_PRESCALE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
`ifdef UPC_COMPARE_EN
   input  logic [WIDTH-1:0] cmp_val,
   output logic             match,
`endif
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(MODULUS - 1);

   if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
      $error("upc_mod: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
   end

   logic             tick;
   logic [WIDTH-1:0] count_nxt;
   logic             wrap_nxt;

   upc_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .clr (load),
      .tick(tick)
   );

   // Load beats a coincident tick; a clamped load never produces a wrap.
   always_comb begin
      count_nxt = count;
      wrap_nxt  = 1'b0;
      if (load) begin
         count_nxt = (load_val > CNT_LAST) ? CNT_LAST : load_val;
      end else if (tick) begin
         if (count == CNT_LAST) begin
            count_nxt = '0;
            wrap_nxt  = 1'b1;
         end else begin
            count_nxt = count + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
         wrap  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         count <= count_nxt;
         wrap  <= wrap_nxt;
         // A wrap on the same edge as a clear keeps the flag set.
         if (wrap_nxt) begin
            ovf <= 1'b1;
         end else if (clr_ovf) begin
            ovf <= 1'b0;
         end
      end
   end

`ifdef UPC_COMPARE_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         match <= 1'b0;
      end else begin
         match <= (count_nxt == cmp_val);
      end
   end
`endif

endmodule

// File: tb/tb_upc_mod.sv
// Table-driven bench for upc_mod: three instances (defaults, MODULUS=10/PRESCALE=3, MODULUS=2/WIDTH=1).
module tb_upc_mod;

   typedef struct {
      int         sel;
      logic       rst;
      logic       en;
      logic       load;
      logic [3:0] load_val;
      logic       clr_ovf;
      logic [3:0] exp_count;
      logic       exp_wrap;
      logic       exp_ovf;
   } vec_t;

   logic clk;

   // Instance A: defaults (WIDTH=4, MODULUS=16, PRESCALE=1)
   logic       a_rst, a_en, a_load, a_clr;
   logic [3:0] a_load_val, a_count;
   logic       a_wrap, a_ovf;
   // Instance B: WIDTH=4, MODULUS=10, PRESCALE=3
   logic       b_rst, b_en, b_load, b_clr;
   logic [3:0] b_load_val, b_count;
   logic       b_wrap, b_ovf;
   // Instance C: WIDTH=1, MODULUS=2, PRESCALE=1
   logic       c_rst, c_en, c_load, c_clr;
   logic [0:0] c_load_val, c_count;
   logic       c_wrap, c_ovf;
`ifdef UPC_COMPARE_EN
   logic [3:0] a_cmp_val, b_cmp_val;
   logic [0:0] c_cmp_val;
   logic       a_match, b_match, c_match;
`endif

   vec_t       vecs[$];
   logic [6:0] exp_q[$];
   int         n_assert;
   int         n_fail;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   upc_mod u_a (
      .clk(clk), .rst(a_rst), .en(a_en), .load(a_load), .load_val(a_load_val),
      .clr_ovf(a_clr),
`ifdef UPC_COMPARE_EN
      .cmp_val(a_cmp_val), .match(a_match),
`endif
      .count(a_count), .wrap(a_wrap), .ovf(a_ovf)
   );

   upc_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_b (
      .clk(clk), .rst(b_rst), .en(b_en), .load(b_load), .load_val(b_load_val),
      .clr_ovf(b_clr),
`ifdef UPC_COMPARE_EN
      .cmp_val(b_cmp_val), .match(b_match),
`endif
      .count(b_count), .wrap(b_wrap), .ovf(b_ovf)
   );

   upc_mod #(.WIDTH(1), .MODULUS(2), .PRESCALE(1)) u_c (
      .clk(clk), .rst(c_rst), .en(c_en), .load(c_load), .load_val(c_load_val),
      .clr_ovf(c_clr),
`ifdef UPC_COMPARE_EN
      .cmp_val(c_cmp_val), .match(c_match),
`endif
      .count(c_count), .wrap(c_wrap), .ovf(c_ovf)
   );

   task automatic add(input int sel, input logic r, input logic e, input logic l,
                      input logic [3:0] lv, input logic c,
                      input logic [3:0] ec, input logic ew, input logic eo);
      vec_t v;
      v.sel = sel; v.rst = r; v.en = e; v.load = l; v.load_val = lv; v.clr_ovf = c;
      v.exp_count = ec; v.exp_wrap = ew; v.exp_ovf = eo;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [3:0] act,
                        input logic [3:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic idle_all();
      a_en = 0; a_load = 0; a_clr = 0; a_load_val = '0;
      b_en = 0; b_load = 0; b_clr = 0; b_load_val = '0;
      c_en = 0; c_load = 0; c_clr = 0; c_load_val = '0;
   endtask

   task automatic drive(input vec_t v);
      idle_all();
      case (v.sel)
         0: begin
            a_rst = v.rst; a_en = v.en; a_load = v.load; a_load_val = v.load_val; a_clr = v.clr_ovf;
         end
         1: begin
            b_rst = v.rst; b_en = v.en; b_load = v.load; b_load_val = v.load_val; b_clr = v.clr_ovf;
         end
         default: begin
            c_rst = v.rst; c_en = v.en; c_load = v.load; c_load_val = v.load_val[0:0]; c_clr = v.clr_ovf;
         end
      endcase
      exp_q.push_back({v.exp_count, v.exp_wrap, v.exp_ovf, (v.sel == 0) && (v.exp_count == 4'd3)});
   endtask

   initial begin
      logic [6:0] e;
      logic [3:0] act_count;
      logic       act_wrap, act_ovf;
      n_assert = 0;
      n_fail   = 0;
      a_rst = 0; b_rst = 0; c_rst = 0;
      idle_all();
`ifdef UPC_COMPARE_EN
      a_cmp_val = 4'd3; b_cmp_val = 4'd15; c_cmp_val = 1'b0;
`endif

      // ---- Instance A: defaults ----
      add(0, 0,0,0,0,0, 0,0,0);
      for (int k = 1; k <= 20; k++)
         add(0, 1,1,0,0,0, 4'(k % 16), k == 16, k >= 16);
      add(0, 1,0,0,0,1,   4,0,0);   // clr_ovf alone clears
      add(0, 1,0,1,15,0, 15,0,0);   // load with en=0 accepted
      add(0, 1,1,0,0,1,   0,1,1);   // wrap coincident with clr: set wins
      add(0, 1,0,0,0,0,   0,0,1);   // wrap is a single-cycle pulse
      add(0, 1,0,1,15,0, 15,0,1);
      add(0, 1,1,1,15,0, 15,0,1);   // load beats tick, no wrap
      add(0, 1,1,1,7,0,   7,0,1);
      add(0, 1,1,0,0,0,   8,0,1);
      add(0, 1,0,1,3,0,   3,0,1);   // load of cmp value
      add(0, 1,1,0,0,0,   4,0,1);
      add(0, 1,0,1,5,0,   5,0,1);
      add(0, 0,1,1,9,0,   0,0,0);   // reset beats load and en
      add(0, 1,1,0,0,0,   1,0,0);
      add(0, 1,1,0,0,0,   2,0,0);

      // ---- Instance B: MODULUS=10, PRESCALE=3 ----
      add(1, 0,0,0,0,0, 0,0,0);
      for (int k = 1; k <= 31; k++)
         add(1, 1,1,0,0,0, 4'((k / 3) % 10), k == 30, k >= 30);
      for (int k = 0; k < 5; k++)
         add(1, 1,0,0,0,0, 0,0,1);  // en low freezes count and phase
      add(1, 1,1,0,0,0,   0,0,1);
      add(1, 1,1,0,0,0,   1,0,1);
      add(1, 1,1,1,7,0,   7,0,1);   // load clears the prescaler phase
      add(1, 1,1,0,0,0,   7,0,1);
      add(1, 1,1,0,0,0,   7,0,1);
      add(1, 1,1,0,0,0,   8,0,1);
      add(1, 1,0,1,12,0,  9,0,1);   // clamp to MODULUS-1
      add(1, 1,1,0,0,0,   9,0,1);
      add(1, 1,1,0,0,0,   9,0,1);
      add(1, 1,1,1,4,0,   4,0,1);   // load on the would-be wrap tick
      add(1, 1,0,0,0,1,   4,0,0);

      // ---- Instance C: WIDTH=1, MODULUS=2 ----
      add(2, 0,0,0,0,0, 0,0,0);
      for (int k = 1; k <= 6; k++)
         add(2, 1,1,0,0,0, 4'(k % 2), (k % 2) == 0, k >= 2);
      add(2, 1,0,1,1,0,   1,0,1);

      @(negedge clk);
      foreach (vecs[i]) begin
         drive(vecs[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         case (vecs[i].sel)
            0: begin act_count = a_count; act_wrap = a_wrap; act_ovf = a_ovf; end
            1: begin act_count = b_count; act_wrap = b_wrap; act_ovf = b_ovf; end
            default: begin act_count = {3'b000, c_count}; act_wrap = c_wrap; act_ovf = c_ovf; end
         endcase
         check("count", i, act_count, e[6:3]);
         check("wrap",  i, {3'b000, act_wrap}, {3'b000, e[2]});
         check("ovf",   i, {3'b000, act_ovf},  {3'b000, e[1]});
`ifdef UPC_COMPARE_EN
         if (vecs[i].sel == 0)
            check("match", i, {3'b000, a_match}, {3'b000, e[0]});
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
